// File: rtl/sigma_adc_defs.sv
// Shared constants and width helpers for the sigma-delta ADC front end.
package sigma_adc_defs;
    localparam int CIC_ORDER    = 2;
    localparam int WARMUP_TICKS = 2;
    localparam int WARM_W       = $clog2(WARMUP_TICKS + 1);

    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

    function automatic int decim_ratio(input int decim_log2);
        return 1 << decim_log2;
    endfunction

    function automatic int sat_max(input int nbits);
        return (1 << (nbits - 1)) - 1;
    endfunction
endpackage

// File: rtl/cic2_decim.sv
// Second-order CIC (sinc2) decimator: integrators run every clock, combs run on each
// decimation tick. c2_o is the comb result valid in the tick cycle (tick_o=1).
module cic2_decim
    import sigma_adc_defs::*;
#(
    parameter int DECIM_LOG2 = 8,
    parameter int W          = cic_width(DECIM_LOG2)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         bit_i,
    output logic [W-1:0] c2_o,
    output logic         tick_o
);
    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [W-1:0]          i2_prev_q, i2_prev_d;
    logic [W-1:0]          c1_prev_q, c1_prev_d;
    logic [W-1:0]          c1;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;

    always_comb begin
        i1_d      = i1_q + W'(bit_i);
        i2_d      = i2_q + i1_d;
        cnt_d     = cnt_q + DECIM_LOG2'(1);
        tick_o    = (cnt_q == DECIM_LOG2'(decim_ratio(DECIM_LOG2) - 1));
        // Combs take the integrator value being written this edge (I2_next).
        c1        = i2_d - i2_prev_q;
        c2_o      = c1 - c1_prev_q;
        i2_prev_d = i2_prev_q;
        c1_prev_d = c1_prev_q;
        if (tick_o) begin
            i2_prev_d = i2_d;
            c1_prev_d = c1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i1_q      <= '0;
            i2_q      <= '0;
            i2_prev_q <= '0;
            c1_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i2_prev_q <= i2_prev_d;
            c1_prev_q <= c1_prev_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: rtl/sigma_adc.sv
// Sigma-delta ADC front end: comparator synchroniser and feedback register, sinc2
// decimation, scaling to signed PCM and a valid/ready output with sticky overrun.
module sigma_adc
    import sigma_adc_defs::*;
#(
    parameter int NBITS      = 16,
    parameter int DECIM_LOG2 = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             comp_i,
    output logic             fb_o,
    output logic [NBITS-1:0] sample_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    input  logic             clear_i
);
    localparam int W     = cic_width(DECIM_LOG2);
    localparam int SHIFT = 2 * DECIM_LOG2 - NBITS;
    localparam logic signed [W:0] OFFSET = (W+1)'(1 << (NBITS - 1));
    localparam logic signed [W:0] SAT_HI = (W+1)'(sat_max(NBITS));

    if (2 * DECIM_LOG2 < NBITS) begin : g_bad_params
        $error("sigma_adc: 2*DECIM_LOG2 must be >= NBITS");
    end

    function automatic logic [NBITS-1:0] scale_sat(input logic [W-1:0] c2);
        logic [W-1:0]      u;
        logic signed [W:0] s;
        u = c2 >> SHIFT;
        s = $signed({1'b0, u}) - OFFSET;
        if (s > SAT_HI) return NBITS'(SAT_HI);
        return NBITS'(s);
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              fb_q, fb_d;
    logic [NBITS-1:0]  sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [W-1:0]      c2;
    logic              tick;
    logic              emit;

    cic2_decim #(
        .DECIM_LOG2(DECIM_LOG2)
    ) u_cic (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bit_i (fb_q),
        .c2_o  (c2),
        .tick_o(tick)
    );

    always_comb begin
        sync1_d   = comp_i;
        sync2_d   = sync1_q;
        fb_d      = sync2_q;
        warm_d    = warm_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        emit      = tick && (warm_q == WARM_W'(WARMUP_TICKS));
        if (tick && !emit) warm_d = warm_q + WARM_W'(1);
        if (valid_q && ready_i) valid_d = 1'b0;
        if (clear_i) overrun_d = 1'b0;
        // A new sample only replaces an unconsumed one if it is being taken this cycle.
        if (emit) begin
            if (!valid_q || ready_i) begin
                sample_d = scale_sat(c2);
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            fb_q      <= 1'b0;
            warm_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            fb_q      <= fb_d;
            warm_q    <= warm_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign fb_o      = fb_q;
    assign sample_o  = sample_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_sigma_adc.sv
// Directed bench for sigma_adc: constant, alternating and 3/4-density bitstreams,
// output back-pressure with overrun/clear, and reset in the middle of operation.
module tb_sigma_adc;
    localparam int NBITS      = 16;
    localparam int DECIM_LOG2 = 8;
    localparam int R          = 256;

    logic             clk_i   = 1'b0;
    logic             rst_i   = 1'b0;
    logic             comp_i  = 1'b0;
    logic             ready_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             fb_o;
    logic             valid_o;
    logic             overrun_o;
    logic [NBITS-1:0] sample_o;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int mode     = 1;
    int phase    = 0;
    logic seen_valid;

    sigma_adc #(
        .NBITS     (NBITS),
        .DECIM_LOG2(DECIM_LOG2)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .comp_i   (comp_i),
        .fb_o     (fb_o),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o),
        .clear_i  (clear_i)
    );

    always #5 clk_i = ~clk_i;

    // mode 0: all zeros, 1: all ones, 2: alternating, 3: three ones then one zero
    function automatic logic pat(input int m, input int p);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return p[0];
            default: return (p % 4) != 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic step();
        comp_i = pat(mode, phase);
        phase++;
        @(posedge clk_i);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step();
    endtask

    task automatic do_reset(input int m);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        mode   = m;
        phase  = 0;
        edge_n = 0;
        rst_i  = 1'b1;
    endtask

    initial begin
        ready_i = 1'b1;
        #2;
        chk("reset_fb", 16'(fb_o), 16'd0);
        chk("reset_sample", sample_o, 16'd0);
        chk("reset_valid", 16'(valid_o), 16'd0);
        chk("reset_overrun", 16'(overrun_o), 16'd0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b1;
        mode   = 1;
        edge_n = 0;

        // All ones: fb latency 3, first sample at 3R, saturated full scale
        step(); step();
        chk("ones_fb_edge2", 16'(fb_o), 16'd0);
        step();
        chk("ones_fb_edge3", 16'(fb_o), 16'd1);
        run_to(3*R - 1);
        chk("ones_valid_before_3R", 16'(valid_o), 16'd0);
        step();
        chk("ones_valid_3R", 16'(valid_o), 16'd1);
        chk("ones_sample_3R", sample_o, 16'd32767);
        step();
        chk("ones_valid_consumed", 16'(valid_o), 16'd0);
        run_to(4*R);
        chk("ones_valid_4R", 16'(valid_o), 16'd1);
        chk("ones_sample_4R", sample_o, 16'd32767);

        // All zeros: negative full scale
        do_reset(0);
        run_to(3*R);
        chk("zeros_valid_3R", 16'(valid_o), 16'd1);
        chk("zeros_sample_3R", sample_o, 16'h8000);
        chk("zeros_fb", 16'(fb_o), 16'd0);
        run_to(4*R);
        chk("zeros_sample_4R", sample_o, 16'h8000);

        // Alternating bits: half scale gives exactly zero
        do_reset(2);
        run_to(3*R);
        chk("alt_valid_3R", 16'(valid_o), 16'd1);
        chk("alt_sample_3R", sample_o, 16'd0);
        run_to(4*R);
        chk("alt_sample_4R", sample_o, 16'd0);

        // Three ones per four bits: C2 = 49152 -> 16384
        do_reset(3);
        run_to(3*R);
        chk("d75_sample_3R", sample_o, 16'd16384);
        run_to(4*R);
        chk("d75_sample_4R", sample_o, 16'd16384);

        // Back-pressure: second sample dropped, first held, overrun set
        do_reset(1);
        ready_i = 1'b0;
        run_to(3*R);
        chk("bp_valid_3R", 16'(valid_o), 16'd1);
        chk("bp_sample_3R", sample_o, 16'd32767);
        chk("bp_overrun_3R", 16'(overrun_o), 16'd0);
        mode = 0;
        run_to(4*R - 1);
        chk("bp_valid_held", 16'(valid_o), 16'd1);
        run_to(4*R);
        chk("bp_sample_held_4R", sample_o, 16'd32767);
        chk("bp_overrun_4R", 16'(overrun_o), 16'd1);
        chk("bp_valid_4R", 16'(valid_o), 16'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("bp_overrun_cleared", 16'(overrun_o), 16'd0);
        chk("bp_valid_after_clear", 16'(valid_o), 16'd1);
        ready_i = 1'b1;
        step();
        chk("bp_valid_dropped", 16'(valid_o), 16'd0);
        ready_i = 1'b0;
        run_to(5*R);
        chk("bp_valid_5R", 16'(valid_o), 16'd1);
        chk("bp_overrun_5R", 16'(overrun_o), 16'd0);
        run_to(6*R - 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("bp_set_beats_clear", 16'(overrun_o), 16'd1);
        chk("bp_valid_6R", 16'(valid_o), 16'd1);

        // Reset while a sample is pending clears outputs without a clock edge
        rst_i = 1'b0;
        #1;
        chk("midrst_sample", sample_o, 16'd0);
        chk("midrst_valid", 16'(valid_o), 16'd0);
        chk("midrst_overrun", 16'(overrun_o), 16'd0);
        chk("midrst_fb", 16'(fb_o), 16'd0);
        ready_i = 1'b1;
        do_reset(1);
        seen_valid = 1'b0;
        while (edge_n < 3*R - 1) begin
            step();
            if (valid_o !== 1'b0) seen_valid = 1'b1;
        end
        chk("midrst_no_early_valid", 16'(seen_valid), 16'd0);
        step();
        chk("midrst_valid_3R", 16'(valid_o), 16'd1);
        chk("midrst_sample_3R", sample_o, 16'd32767);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
